// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: shares one downstream APB master port among MASTER_PORTS
// requesters with round-robin grant and an ACCESS-phase timeout.
module apb_rr_arbiter #(
  parameter int BUS_WIDTH    = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int MASTER_PORTS = 4,
  parameter int TIMEOUT      = 255,
  parameter int ERRW         = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0]  S_PADDR,
  input  logic [MASTER_PORTS-1:0]            S_PWRITE,
  input  logic [MASTER_PORTS-1:0]            S_PSELx,
  input  logic [MASTER_PORTS-1:0]            S_PENABLE,
  input  logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PWDATA,
  output logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PRDATA,
  output logic [MASTER_PORTS-1:0]            S_PREADY,
  output logic [MASTER_PORTS-1:0]            S_PSLVERR,
  output logic [BUS_WIDTH-1:0]               M_PADDR,
  output logic                               M_PWRITE,
  output logic                               M_PSEL,
  output logic                               M_PENABLE,
  output logic [DATA_WIDTH-1:0]              M_PWDATA,
  input  logic [DATA_WIDTH-1:0]              M_PRDATA,
  input  logic                               M_PREADY,
  output logic [MASTER_PORTS-1:0]            grant,
  output logic [ERRW-1:0]                    err_count
);

  localparam int AW = (MASTER_PORTS > 1) ? $clog2(MASTER_PORTS) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t          state;
  logic [AW-1:0]   active;
  logic [AW-1:0]   last;
  logic [TW-1:0]   tcnt;
  logic [AW-1:0]   pick;
  logic [AW-1:0]   cand;
  logic            found;
  logic            busy;
  logic            acc;
  logic            tmo;
  logic            done;
  logic            unused_penable;

  // Masters drive their own PENABLE, but the arbiter sequences the phases.
  assign unused_penable = ^S_PENABLE;

  assign busy = (state != IDLE);
  assign acc  = (state == ACCESS);
  assign tmo  = (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT - 1));
  assign done = acc && (M_PREADY || tmo);

  assign M_PSEL    = busy;
  assign M_PENABLE = acc;

  // First requester after the previous owner, wrapping around.
  always_comb begin
    pick  = last;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= MASTER_PORTS; k++) begin
      cand = AW'((int'(last) + k) % MASTER_PORTS);
      if (!found && S_PSELx[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      active    <= '0;
      last      <= AW'(MASTER_PORTS - 1);
      tcnt      <= '0;
      err_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|S_PSELx) begin
            active <= pick;
            state  <= SETUP;
          end
        end
        SETUP: begin
          tcnt  <= '0;
          state <= ACCESS;
        end
        ACCESS: begin
          tcnt <= tcnt + 1'b1;
          if (M_PREADY || tmo) begin
            last  <= active;
            state <= IDLE;
            if (!M_PREADY && !(&err_count))
              err_count <= err_count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    M_PADDR   = '0;
    M_PWRITE  = 1'b0;
    M_PWDATA  = '0;
    grant     = '0;
    S_PREADY  = '0;
    S_PSLVERR = '0;
    S_PRDATA  = '0;
    for (int i = 0; i < MASTER_PORTS; i++) begin
      if (busy && (active == AW'(i))) begin
        M_PADDR      = S_PADDR[i*BUS_WIDTH +: BUS_WIDTH];
        M_PWRITE     = S_PWRITE[i];
        M_PWDATA     = S_PWDATA[i*DATA_WIDTH +: DATA_WIDTH];
        grant[i]     = 1'b1;
        S_PREADY[i]  = done;
        S_PSLVERR[i] = done && !M_PREADY;
        if (done && M_PREADY)
          S_PRDATA[i*DATA_WIDTH +: DATA_WIDTH] = M_PRDATA;
      end
    end
  end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// tb_apb_rr_arbiter: vector table, directed corner sequences and random
// traffic checked against a transaction-level model of the arbiter.
module tb_apb_rr_arbiter;

  localparam int MP  = 4;
  localparam int BW  = 16;
  localparam int DW  = 16;
  localparam int TMO = 4;
  localparam int EW  = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [MP*BW-1:0] S_PADDR;
  logic [MP-1:0]   S_PWRITE;
  logic [MP-1:0]   S_PSELx;
  logic [MP-1:0]   S_PENABLE;
  logic [MP*DW-1:0] S_PWDATA;
  logic [MP*DW-1:0] S_PRDATA;
  logic [MP-1:0]   S_PREADY;
  logic [MP-1:0]   S_PSLVERR;
  logic [BW-1:0]   M_PADDR;
  logic            M_PWRITE;
  logic            M_PSEL;
  logic            M_PENABLE;
  logic [DW-1:0]   M_PWDATA;
  logic [DW-1:0]   M_PRDATA;
  logic            M_PREADY;
  logic [MP-1:0]   grant;
  logic [EW-1:0]   err_count;

  apb_rr_arbiter #(
    .BUS_WIDTH(BW), .DATA_WIDTH(DW), .MASTER_PORTS(MP),
    .TIMEOUT(TMO), .ERRW(EW)
  ) dut (
    .clk(clk), .reset(reset),
    .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE), .S_PSELx(S_PSELx),
    .S_PENABLE(S_PENABLE), .S_PWDATA(S_PWDATA), .S_PRDATA(S_PRDATA),
    .S_PREADY(S_PREADY), .S_PSLVERR(S_PSLVERR),
    .M_PADDR(M_PADDR), .M_PWRITE(M_PWRITE), .M_PSEL(M_PSEL),
    .M_PENABLE(M_PENABLE), .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA),
    .M_PREADY(M_PREADY), .grant(grant), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks;
  int errors;

  // Model: owner of the bus (-1 = none), cycles since grant, last owner.
  int owner;
  int age;
  int last;
  int errc;

  typedef struct {
    logic        rst;
    logic [3:0]  psel;
    logic        rdy;
    logic [15:0] prd;
    logic        sel;
    logic        en;
    logic [3:0]  gnt;
    logic [3:0]  srdy;
    logic [63:0] rdat;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rst, logic [3:0] psel, logic rdy,
                              logic [15:0] prd, logic sel, logic en,
                              logic [3:0] gnt, logic [3:0] srdy,
                              logic [63:0] rdat);
    vec_t v;
    v.rst = rst; v.psel = psel; v.rdy = rdy; v.prd = prd;
    v.sel = sel; v.en = en; v.gnt = gnt; v.srdy = srdy; v.rdat = rdat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_chk();
    logic [BW-1:0] e_addr;
    logic          e_wr;
    logic [DW-1:0] e_wd;
    logic [MP-1:0] e_gnt, e_rdy, e_err;
    logic [MP*DW-1:0] e_rd;
    logic          e_sel, e_en;
    e_addr = '0; e_wr = 1'b0; e_wd = '0; e_gnt = '0; e_rdy = '0;
    e_err = '0; e_rd = '0; e_sel = 1'b0; e_en = 1'b0;
    if (owner >= 0) begin
      e_sel = 1'b1;
      e_en  = (age >= 1);
      e_addr = S_PADDR[owner*BW +: BW];
      e_wr   = S_PWRITE[owner];
      e_wd   = S_PWDATA[owner*DW +: DW];
      e_gnt[owner] = 1'b1;
      if (age >= 1) begin
        if (M_PREADY) begin
          e_rdy[owner] = 1'b1;
          e_rd[owner*DW +: DW] = M_PRDATA;
        end else if (age == TMO) begin
          e_rdy[owner] = 1'b1;
          e_err[owner] = 1'b1;
        end
      end
    end
    chk("model",
        {M_PSEL, M_PENABLE, M_PADDR, M_PWRITE, M_PWDATA, grant,
         S_PREADY, S_PSLVERR, S_PRDATA, err_count},
        {e_sel, e_en, e_addr, e_wr, e_wd, e_gnt,
         e_rdy, e_err, e_rd, EW'(errc)});
  endtask

  task automatic model_upd();
    if (reset) begin
      owner = -1; age = 0; last = MP - 1; errc = 0;
    end else if (owner < 0) begin
      if (|S_PSELx) begin
        for (int k = 1; k <= MP; k++) begin
          if (owner < 0 && S_PSELx[(last + k) % MP]) owner = (last + k) % MP;
        end
        age = 0;
      end
    end else if (age >= 1 && (M_PREADY || age == TMO)) begin
      if (!M_PREADY && errc < (1 << EW) - 1) errc++;
      last  = owner;
      owner = -1;
    end else begin
      age++;
    end
  endtask

  // Called 1 time unit after inputs settle; returns just after next negedge.
  task automatic cyc();
    model_chk();
    @(posedge clk);
    model_upd();
    @(negedge clk);
    #1;
  endtask

  task automatic drv(input logic [3:0] p, input logic r, input logic [15:0] d);
    S_PSELx  = p;
    M_PREADY = r;
    M_PRDATA = d;
    #1;
  endtask

  initial begin
    checks = 0; errors = 0;
    owner = -1; age = 0; last = MP - 1; errc = 0;
    reset = 1'b1;
    S_PSELx = '0; S_PENABLE = '0; S_PWRITE = '0;
    S_PADDR = {16'h0310, 16'h0210, 16'h0110, 16'h0010};
    S_PWDATA = '0; M_PREADY = 1'b0; M_PRDATA = '0;

    // single read from master 0, then reset, then four-way round robin
    vq.push_back(mk(0, 4'b0001, 0, 16'h0000, 0, 0, 4'b0000, 4'b0000, 64'h0));
    vq.push_back(mk(0, 4'b0001, 0, 16'hAAAA, 1, 0, 4'b0001, 4'b0000, 64'h0));
    vq.push_back(mk(0, 4'b0001, 1, 16'hBEEF, 1, 1, 4'b0001, 4'b0001,
                    64'h0000_0000_0000_BEEF));
    vq.push_back(mk(0, 4'b0000, 0, 16'h0000, 0, 0, 4'b0000, 4'b0000, 64'h0));
    vq.push_back(mk(1, 4'b1111, 1, 16'h7777, 0, 0, 4'b0000, 4'b0000, 64'h0));
    for (int k = 0; k < 5; k++) begin
      int m;
      logic [15:0] d;
      m = k % 4;
      d = 16'h5A00 + 16'(k);
      vq.push_back(mk(0, 4'b1111, 1, d, 0, 0, 4'b0000, 4'b0000, 64'h0));
      vq.push_back(mk(0, 4'b1111, 1, d, 1, 0, 4'(1 << m), 4'b0000, 64'h0));
      vq.push_back(mk(0, 4'b1111, 1, d, 1, 1, 4'(1 << m), 4'(1 << m),
                      64'(d) << (16 * m)));
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_out",
        {M_PSEL, M_PENABLE, M_PADDR, M_PWRITE, M_PWDATA, grant,
         S_PREADY, S_PSLVERR, S_PRDATA, err_count}, '0);
    cyc();
    reset = 1'b0;

    foreach (vq[i]) begin
      reset = vq[i].rst;
      drv(vq[i].psel, vq[i].rdy, vq[i].prd);
      chk($sformatf("vec%0d", i),
          {M_PSEL, M_PENABLE, grant, S_PREADY, S_PSLVERR, S_PRDATA},
          {vq[i].sel, vq[i].en, vq[i].gnt, vq[i].srdy, 4'b0000, vq[i].rdat});
      cyc();
    end
    reset = 1'b0;

    // master 1 alone, then master 2 write with 3 wait states vs master 1
    drv(4'b0010, 0, 16'h0); cyc();
    drv(4'b0010, 0, 16'h0); chk("t3_m1_setup", grant, 4'b0010); cyc();
    drv(4'b0010, 1, 16'h1111); chk("t3_m1_done", S_PREADY, 4'b0010); cyc();
    S_PADDR[47:32] = 16'h0100;
    S_PWRITE[2] = 1'b1;
    S_PWDATA[47:32] = 16'h1234;
    drv(4'b0110, 0, 16'h0); chk("t3_idle", grant, 4'b0000); cyc();
    drv(4'b0110, 0, 16'h0);
    chk("t3_setup", {grant, M_PADDR, M_PWRITE, M_PWDATA, M_PENABLE},
        {4'b0100, 16'h0100, 1'b1, 16'h1234, 1'b0});
    cyc();
    for (int a = 1; a <= 3; a++) begin
      drv(4'b0110, 0, 16'h0);
      chk("t3_wait", {grant, M_PWDATA, M_PENABLE, S_PREADY},
          {4'b0100, 16'h1234, 1'b1, 4'b0000});
      cyc();
    end
    // ready lands on the timeout cycle: completes without error
    drv(4'b0110, 1, 16'h4321);
    chk("t3_done", {M_PWDATA, S_PREADY, S_PSLVERR, err_count},
        {16'h1234, 4'b0100, 4'b0000, 2'd0});
    cyc();
    drv(4'b0010, 0, 16'h0);
    chk("t3_after", {grant, err_count}, {4'b0000, 2'd0});
    cyc();
    drv(4'b0010, 0, 16'h0); chk("t3_m1_next", grant, 4'b0010); cyc();
    drv(4'b0010, 1, 16'h0); cyc();

    // hung slave: repeated timeouts alternate masters 3 and 0
    for (int n = 0; n < 5; n++) begin
      logic [3:0] g;
      g = (n % 2 == 0) ? 4'b1000 : 4'b0001;
      drv(4'b1001, 0, 16'hFFFF);
      chk("t4_idle", {grant, err_count}, {4'b0000, EW'(n < 3 ? n : 3)});
      cyc();
      drv(4'b1001, 0, 16'hFFFF); chk("t4_setup", grant, g); cyc();
      for (int a = 1; a <= 4; a++) begin
        drv(4'b1001, 0, 16'hFFFF);
        if (a < 4) chk("t4_wait", {S_PREADY, S_PSLVERR}, 8'h00);
        else chk("t4_tmo", {S_PREADY, S_PSLVERR, S_PRDATA}, {g, g, 64'h0});
        cyc();
      end
    end
    drv(4'b0000, 0, 16'h0); chk("t4_sat", err_count, 2'd3); cyc();

    // reset in the middle of an ACCESS phase
    drv(4'b0100, 0, 16'h0); cyc();
    drv(4'b0100, 0, 16'h0); chk("t5_setup", grant, 4'b0100); cyc();
    reset = 1'b1;
    drv(4'b0100, 0, 16'h0);
    chk("t5_acc", {M_PENABLE, S_PREADY}, {1'b1, 4'b0000});
    cyc();
    reset = 1'b0;
    drv(4'b1111, 0, 16'h0);
    chk("t5_cleared",
        {M_PSEL, M_PENABLE, M_PADDR, M_PWRITE, M_PWDATA, grant,
         S_PREADY, S_PSLVERR, S_PRDATA, err_count}, '0);
    cyc();
    drv(4'b1111, 0, 16'h0); chk("t5_first", grant, 4'b0001); cyc();
    drv(4'b1111, 1, 16'h0); chk("t5_done", S_PREADY, 4'b0001); cyc();

    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 199) == 0);
      S_PSELx   = 4'($urandom_range(0, 15));
      S_PENABLE = 4'($urandom_range(0, 15));
      S_PWRITE  = 4'($urandom_range(0, 15));
      S_PADDR   = {$urandom, $urandom};
      S_PWDATA  = {$urandom, $urandom};
      M_PREADY  = ($urandom_range(0, 9) < 3);
      M_PRDATA  = 16'($urandom);
      #1;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
